// File: rtl/pc_fetch_sequencer.sv
// Front-end sequencer: owns the PC write-enable/next-value decision and the single
// outstanding instruction fetch, including redirect latching and wrong-path flushes.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned PC_STEP      = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] pc_cur,
    output logic        pc_write,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        trap,
    output logic        flush,
    output logic        redirect_pending
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic        pend_trap_q, pend_trap_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        redir;
    logic [31:0] redir_target;
    logic        keep_pend;
    logic [31:0] seq_pc;
    logic        write_c, flush_c, req_c;
    logic [31:0] next_c;

    // Redirect source selection: trap > jmp > br_taken, targets word-aligned.
    always_comb begin
        redir = trap | jmp | br_taken;
        if (trap)     redir_target = TRAP_VECTOR;
        else if (jmp) redir_target = jmp_target;
        else          redir_target = br_target;
        redir_target[1:0] = 2'b00;
        // A latched trap may only be displaced by another trap.
        keep_pend = pend_valid_q & pend_trap_q & ~trap;
        seq_pc    = pc_cur + 32'(PC_STEP);
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_trap_d   = pend_trap_q;
        pend_target_d = pend_target_q;
        write_c       = 1'b0;
        flush_c       = 1'b0;
        req_c         = 1'b0;
        next_c        = '0;

        case (state_q)
            ST_BOOT: begin
                write_c = 1'b1;
                next_c  = {RESET_VECTOR[31:2], 2'b00};
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                req_c = 1'b1;
                if (!imem_ack) begin
                    if (redir && !keep_pend) begin
                        pend_valid_d  = 1'b1;
                        pend_trap_d   = trap;
                        pend_target_d = redir_target;
                    end
                end else if (redir || pend_valid_q) begin
                    write_c      = 1'b1;
                    flush_c      = 1'b1;
                    next_c       = (redir && !keep_pend) ? redir_target : pend_target_q;
                    pend_valid_d = 1'b0;
                    pend_trap_d  = 1'b0;
                end else if (!stall) begin
                    write_c = 1'b1;
                    next_c  = seq_pc;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redir) begin
                    write_c = 1'b1;
                    flush_c = 1'b1;
                    next_c  = redir_target;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    write_c = 1'b1;
                    next_c  = seq_pc;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q       <= ST_BOOT;
            pend_valid_q  <= 1'b0;
            pend_trap_q   <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_trap_q   <= pend_trap_d;
            pend_target_q <= pend_target_d;
        end
    end

    // BOOT decodes to a write, so the combinational outputs are gated while reset is held.
    assign pc_write         = res & write_c;
    assign pc_next          = res ? next_c : '0;
    assign flush            = res & flush_c;
    assign imem_req         = res & req_c;
    assign imem_addr        = pc_cur;
    assign redirect_pending = pend_valid_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: a queue-based reference model predicts
// every PC write; a monitor on the falling edge pops and compares.
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] STEP     = 32'd4;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [31:0] pc_cur;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        trap = 1'b0;
    logic        flush;
    logic        redirect_pending;

    pc_fetch_sequencer dut (
        .clk(clk), .res(res), .pc_cur(pc_cur), .pc_write(pc_write), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .stall(stall),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
        .trap(trap), .flush(flush), .redirect_pending(redirect_pending)
    );

    always #5 clk = ~clk;

    // Environment PC register, written by the sequencer.
    logic [31:0] pc_reg = '0;
    assign pc_cur = pc_reg;
    always @(posedge clk) if (pc_write) pc_reg <= pc_next;

    typedef struct { int cyc; logic [31:0] pc; logic fl; } wr_t;
    typedef struct { logic [31:0] tgt; bit is_trap; } redir_t;

    wr_t    exp_q[$];
    redir_t pend_q[$];
    bit     m_boot = 1'b1;
    bit     m_hold = 1'b0;
    bit     exp_req = 1'b0;
    bit     exp_pend = 1'b0;
    bit     res_next = 1'b0;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", name, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic expect_write(input logic [31:0] pc, input logic fl);
        wr_t w;
        w.cyc = cyc;
        w.pc  = pc;
        w.fl  = fl;
        exp_q.push_back(w);
    endtask

    task automatic model_reset();
        m_boot   = 1'b1;
        m_hold   = 1'b0;
        pend_q.delete();
        exp_req  = 1'b0;
        exp_pend = 1'b0;
    endtask

    // Drive one cycle of inputs just after the rising edge and predict its outcome.
    task automatic step(input bit a, input bit s, input bit b, input logic [31:0] bt,
                        input bit j, input logic [31:0] jt, input bit t);
        redir_t r;
        bit     have;
        bit     keep;
        @(posedge clk);
        #1;
        res = res_next;
        imem_ack = a; stall = s; br_taken = b; br_target = bt;
        jmp = j; jmp_target = jt; trap = t;
        cyc++;
        if (!res) begin
            model_reset();
            return;
        end
        exp_pend  = (pend_q.size() != 0);
        have      = t | j | b;
        r.is_trap = t;
        r.tgt     = t ? align(TRAP_VEC) : (j ? align(jt) : align(bt));
        keep      = (pend_q.size() != 0) && pend_q[0].is_trap && !t;
        if (m_boot) begin
            exp_req = 1'b0;
            expect_write(align(RST_VEC), 1'b0);
            m_boot = 1'b0;
        end else if (m_hold) begin
            exp_req = 1'b0;
            if (have) begin
                expect_write(r.tgt, 1'b1);
                m_hold = 1'b0;
            end else if (!s) begin
                expect_write(pc_reg + STEP, 1'b0);
                m_hold = 1'b0;
            end
        end else begin
            exp_req = 1'b1;
            if (!a) begin
                if (have && !keep) begin
                    pend_q.delete();
                    pend_q.push_back(r);
                end
            end else if (have || pend_q.size() != 0) begin
                expect_write((have && !keep) ? r.tgt : pend_q[0].tgt, 1'b1);
                pend_q.delete();
            end else if (!s) begin
                expect_write(pc_reg + STEP, 1'b0);
            end else begin
                m_hold = 1'b1;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, '0, 0);
    endtask

    // Assert reset between clock edges and confirm outputs collapse without an edge.
    task automatic mid_reset();
        #2;
        res = 1'b0;
        res_next = 1'b0;
        #1;
        check_bit("async_rst_imem_req", imem_req, 1'b0);
        check_bit("async_rst_pc_write", pc_write, 1'b0);
        check_bit("async_rst_redirect_pending", redirect_pending, 1'b0);
        model_reset();
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (pc_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pc_write @cycle %0d: got pc_next=%h, expected no write", cyc, pc_next);
                end else begin
                    e = exp_q.pop_front();
                    check_word("write_cycle", 32'(cyc), 32'(e.cyc));
                    check_word("pc_next", pc_next, e.pc);
                    check_bit("flush", flush, e.fl);
                end
            end else begin
                check_bit("flush_idle", flush, 1'b0);
                if (!res) check_word("pc_next_in_reset", pc_next, '0);
            end
            check_bit("imem_req", imem_req, exp_req);
            check_bit("redirect_pending", redirect_pending, exp_pend);
            if (exp_req) check_word("imem_addr", imem_addr, pc_reg);
        end
    end

    initial begin
        bit a, s, b, j, t;
        repeat (2) idle();
        res_next = 1'b1;

        // Boot, then sequential fetches.
        idle();
        idle();
        step(1, 0, 0, '0, 0, '0, 0);
        step(1, 0, 0, '0, 0, '0, 0);

        // Branch latched during a slow fetch.
        step(0, 0, 1, 32'h40, 0, '0, 0);
        idle();
        idle();
        step(1, 0, 0, '0, 0, '0, 0);

        // Trap beats jump on the ack cycle; latched trap survives a later branch.
        step(1, 0, 0, '0, 1, 32'h80, 1);
        step(0, 0, 0, '0, 0, '0, 1);
        step(0, 0, 1, 32'h20, 0, '0, 0);
        step(1, 0, 0, '0, 0, '0, 0);

        // Stall into HOLD at 0x10, release, then a jump redirect while holding.
        step(0, 0, 0, '0, 1, 32'h10, 0);
        step(1, 0, 0, '0, 0, '0, 0);
        step(1, 1, 0, '0, 0, '0, 0);
        repeat (4) step(0, 1, 0, '0, 0, '0, 0);
        idle();
        step(1, 1, 0, '0, 0, '0, 0);
        step(0, 1, 0, '0, 1, 32'h33, 0);

        // Sequential wrap at the top of the address space.
        step(0, 0, 0, '0, 1, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, '0, 0, '0, 0);
        step(1, 0, 0, '0, 0, '0, 0);

        // Reset mid-wait with a pending redirect; stale ack during BOOT is ignored.
        step(0, 0, 1, 32'h44, 0, '0, 0);
        idle();
        mid_reset();
        repeat (2) idle();
        res_next = 1'b1;
        step(1, 0, 0, '0, 0, '0, 0);
        idle();
        step(1, 0, 0, '0, 0, '0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            a = !m_boot && !m_hold && ($urandom_range(2) == 0);
            s = ($urandom_range(2) == 0);
            b = ($urandom_range(7) == 0);
            j = ($urandom_range(7) == 0);
            t = ($urandom_range(15) == 0);
            step(a, s, b, $urandom, j, $urandom, t);
        end
        idle();

        @(negedge clk);
        #1;
        check_word("expected_writes_drained", 32'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controls the program-counter register and the instruction-memory fetch handshake in the RISC-V core.
- Decides when the PC register is written (pc_write) and with what value (pc_next), choosing between sequential, branch, jump, trap and boot-vector sources.
- Holds fetch during hazard stalls.
- Discards in-flight wrong-path fetches when a redirect arrives.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on the first cycle after reset release.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- res  input  1  reset; asynchronous, active-low (res=0 resets immediately, independent of clk).
- pc_cur  input  32  current PC register output.
- pc_write  output  1  write enable to the PC register.
- pc_next  output  32  value written to the PC register when pc_write=1.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc_cur.
- imem_ack  input  1  instruction memory has returned the fetch; single-cycle pulse.
- stall  input  1  hazard unit requests the front end to freeze.
- br_taken  input  1  branch resolved taken this cycle.
- br_target  input  32  branch target.
- jmp  input  1  jump (JAL/JALR) this cycle.
- jmp_target  input  32  jump target.
- trap  input  1  exception/trap this cycle.
- flush  output  1  current/just-returned instruction is wrong-path; decode must drop it.
- redirect_pending  output  1  a redirect is latched, waiting for the outstanding fetch.

Behaviour:
- **Reset (res=0):**
  - State=BOOT; pend_valid=0; pend_target=0.
  - Outputs: pc_write=0, pc_next=0, imem_req=0, flush=0, redirect_pending=0.
  - Applies mid-transaction too; an outstanding fetch is abandoned and a late imem_ack is ignored.
- **FSM states:** BOOT, FETCH, HOLD.
- **BOOT:**
  - First clock edge with res=1: combinational outputs are pc_write=1, pc_next=RESET_VECTOR.
  - Next state FETCH. imem_req=0 in BOOT.
- **FETCH:**
  - imem_req=1, imem_addr=pc_cur; both held stable until imem_ack.
  - Redirect priority: trap > jmp > br_taken.
  - Redirect seen while imem_ack=0:
    - Latch the target into pend_target; set pend_valid.
    - A later redirect overwrites a pending one, except that a latched trap is only overwritten by another trap.
    - pc_write=0.
  - imem_ack=1 with pend_valid=1 or a same-cycle redirect:
    - flush=1, pc_write=1.
    - pc_next = same-cycle redirect if present by priority (trap still wins over a latched non-trap), else pend_target.
    - Clear pend_valid. Stay in FETCH.
  - imem_ack=1, no redirect, stall=0: pc_write=1, pc_next=pc_cur+PC_STEP; stay in FETCH.
  - imem_ack=1, no redirect, stall=1: pc_write=0; go to HOLD.
- **HOLD:**
  - imem_req=0, pc_write=0 while stall=1 and no redirect.
  - stall falls: pc_write=1, pc_next=pc_cur+PC_STEP; go to FETCH.
  - A redirect in HOLD applies immediately, regardless of stall: pc_write=1, pc_next=target, flush=1; go to FETCH.
- redirect_pending = pend_valid (registered).
- Width rules:
  - pc_cur+PC_STEP is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
  - All targets have bits [1:0] forced to 0 before use.
- pc_write is asserted at most once per clock; there is never more than one outstanding fetch.
- flush is a single-cycle pulse, coincident with the corresponding pc_write.

Test Plan:
- Reset release with RESET_VECTOR=0: cycle 1 pc_write=1, pc_next=0. Then imem_req=1, addr=0; ack -> pc_next=4; next ack -> pc_next=8.
- imem_ack delayed 3 cycles, br_taken=1 with br_target=0x40 at cycle 1 of the wait -> redirect_pending=1 for 2 cycles. On ack: flush=1, pc_write=1, pc_next=0x40, redirect_pending=0.
- jmp (0x80) and trap in the same cycle as ack -> pc_next=0x100, flush=1. Then, with trap latched during a wait, a later br_taken (0x20) -> pc_next stays 0x100.
- Ack with stall=1 at pc_cur=0x10 -> HOLD: pc_write=0 and imem_req=0 for 4 stall cycles. stall falls -> pc_next=0x14. Separately, jmp to 0x33 arriving in HOLD -> pc_next=0x30, flush=1.
- pc_cur=0xFFFF_FFFC, ack, no stall -> pc_next=0x0000_0000.
- res driven low mid-wait (between clock edges) -> imem_req, pc_write and redirect_pending drop immediately without a clock edge. After release, the BOOT sequence repeats and a stale ack is ignored.
